// File: rtl/axi4_sram_bridge.sv
`timescale 1ns/1ps
// axi4_sram_bridge: converts an SRAM-style requestor port into single-beat AXI4 master transactions.
// Latency: best case 3 stall cycles (AW/W, B or AR, R, then RESP); misaligned accesses trap in 1 cycle.
// Backpressure: mem_stall holds the requestor until the RESP cycle; at most one AXI transaction in flight.
// Ports: ACLK/ARESET (sync, active-high); AXI4 AW/W/B/AR/R master channels; mem_* requestor
//        port (addr, wdata, c_en, w_en, b_en in; rdata, stall, error out); err_count event counter.
module axi4_sram_bridge #(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 32,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] TXN_ID = '0,
  parameter logic [2:0]      PROT   = 3'b000
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // write address channel
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic [3:0]          AWQOS,
  output logic [3:0]          AWREGION,
  output logic                AWVALID,
  input  logic                AWREADY,
  // write data channel
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // write response channel
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // read address channel
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic [3:0]          ARQOS,
  output logic [3:0]          ARREGION,
  output logic                ARVALID,
  input  logic                ARREADY,
  // read data channel
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  // SRAM-style requestor port
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_c_en,
  input  logic                mem_w_en,
  input  logic [DATA_W/8-1:0] mem_b_en,
  output logic                mem_stall,
  output logic                mem_error,
  output logic [7:0]          err_count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA_S, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                aw_done, w_done;
  logic [DATA_W-1:0]   rdata_q;
  logic                error_q;
  logic                misaligned;
  logic                aw_hs, w_hs, wr_both;

  assign misaligned = |mem_addr[OFF_W-1:0];

  // Handshakes only count while the corresponding VALID is actually driven.
  assign aw_hs   = (state == WADDR) & ~aw_done & AWREADY;
  assign w_hs    = (state == WADDR) & ~w_done & WREADY;
  assign wr_both = (aw_done | aw_hs) & (w_done | w_hs);

  // Fixed single-beat, full-width INCR attributes.
  assign AWID     = TXN_ID;
  assign AWADDR   = addr_q;
  assign AWLEN    = 8'd0;
  assign AWSIZE   = 3'(OFF_W);
  assign AWBURST  = 2'b01;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'd0;
  assign AWPROT   = PROT;
  assign AWQOS    = 4'd0;
  assign AWREGION = 4'd0;
  assign WDATA    = wdata_q;
  assign WSTRB    = strb_q;
  assign WLAST    = 1'b1;
  assign ARID     = TXN_ID;
  assign ARADDR   = addr_q;
  assign ARLEN    = 8'd0;
  assign ARSIZE   = 3'(OFF_W);
  assign ARBURST  = 2'b01;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'd0;
  assign ARPROT   = PROT;
  assign ARQOS    = 4'd0;
  assign ARREGION = 4'd0;

  // Stall is combinational from mem_c_en so an idle request is held off in the same cycle.
  assign mem_stall = mem_c_en & (state != RESP);
  assign mem_error = error_q & (state == RESP);
  assign mem_rdata = rdata_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_c_en) begin
          if (misaligned)    state_nxt = RESP;
          else if (mem_w_en) state_nxt = WADDR;
          else               state_nxt = RADDR;
        end
      end
      WADDR: begin
        // AW and W complete independently; each VALID drops after its own handshake.
        AWVALID = ~aw_done;
        WVALID  = ~w_done;
        if (wr_both) state_nxt = WRESP;
      end
      WRESP: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = RESP;
      end
      RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = RDATA_S;
      end
      RDATA_S: begin
        RREADY = 1'b1;
        if (RVALID) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_c_en) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            strb_q  <= mem_b_en;
            // A misaligned request goes straight to RESP, so its error is known here.
            error_q <= misaligned;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WADDR: begin
          if (wr_both) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WRESP: begin
          if (BVALID) error_q <= (BRESP != 2'b00) | (BID != TXN_ID);
        end
        RDATA_S: begin
          if (RVALID) begin
            rdata_q <= RDATA;
            error_q <= (RRESP != 2'b00) | (RID != TXN_ID) | ~RLAST;
          end
        end
        RESP: begin
          if (error_q && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi4_sram_bridge.md
# axi4_sram_bridge

Parametrised bridge that converts a single-requestor SRAM-style interface (chip enable, write enable, byte enables, stall, error) into single-beat AXI4 master transactions. It sits between the core's memory port and the system interconnect. It is the width- and ID-configurable successor of the fixed 32-bit bridge. It adds AXI response/ID error mapping, misaligned-access trapping without bus traffic, and an error event counter.

## Interface
- ADDR_W, 32, address width (AXI and SRAM side).
- DATA_W, 32, data width; legal values 32 or 64.
- ID_W, 4, AXI ID width.
- TXN_ID, 0, constant ID driven on AWID/ARID and expected on BID/RID.
- PROT, 3'b000, constant value for AWPROT/ARPROT.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset; synchronous and active-high.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION  out  ID_W/ADDR_W/8/3/2/1/4/3/4/4  write address fields.
- AWVALID  out  1;  AWREADY  in  1.
- WDATA  out  DATA_W;  WSTRB  out  DATA_W/8;  WLAST  out  1;  WVALID  out  1;  WREADY  in  1.
- BID  in  ID_W;  BRESP  in  2;  BVALID  in  1;  BREADY  out  1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION  out  same widths as AW*; ARVALID  out  1;  ARREADY  in  1.
- RID  in  ID_W;  RDATA  in  DATA_W;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  DATA_W;  mem_rdata  out  DATA_W.
- mem_c_en  in  1  request;  mem_w_en  in  1  1=write;  mem_b_en  in  DATA_W/8  byte enables.
- mem_stall  out  1;  mem_error  out  1.
- err_count  out  8  saturating count of completed requests with mem_error=1.

## Operation
- Constant fields: xLEN=0, xSIZE=log2(DATA_W/8), xBURST=2'b01 (INCR), xLOCK=0, xCACHE=0, xQOS=0, xREGION=0, WLAST=1, xID=TXN_ID, xPROT=PROT.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE: on mem_c_en, register addr/wdata/b_en/w_en. If misaligned (mem_addr[log2(DATA_W/8)-1:0]!=0), go to RESP with error=1 and issue no AXI traffic. Otherwise go to WADDR (write) or RADDR (read).
- WADDR: AWVALID and WVALID both asserted. Track aw_done and w_done independently; each VALID drops after its own handshake. When both are done, go to WRESP. AWADDR/WDATA/WSTRB hold the registered values.
- WRESP: BREADY=1. On BVALID, error = (BRESP!=2'b00) | (BID!=TXN_ID). Go to RESP.
- RADDR: ARVALID=1. On ARREADY, go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA into rdata_q. Error = (RRESP!=0) | (RID!=TXN_ID) | !RLAST. Go to RESP.
- RESP: exactly one cycle, then IDLE. err_count increments if error, saturating at 255.
- mem_stall = mem_c_en & (state!=RESP). This path is combinational from mem_c_en.
- mem_rdata = rdata_q, valid in the RESP cycle of a read. mem_error = error_q & (state==RESP).
- Requestor holds all request inputs stable while mem_stall=1. Inputs are sampled only in IDLE.
- A write with mem_b_en=0 is still issued, with WSTRB=0.

## Timing
- Reset: state=IDLE; all VALID/READY outputs 0; aw_done=w_done=0; rdata_q=0; error_q=0; err_count=0. mem_stall follows mem_c_en; mem_error=0.
- ARESET mid-transaction: state returns to IDLE next edge; the outstanding AXI transaction is abandoned. The system resets the interconnect together with this block.
- Best-case write (AWREADY=WREADY=1 at first VALID, BVALID in the cycle after): request at cycle 0, AW/W handshake at cycle 1, B at cycle 2, RESP at cycle 3. That is 3 stall cycles.
- Best-case read: request at cycle 0, AR at cycle 1, R at cycle 2, RESP at cycle 3.
- Misaligned access: request at cycle 0, RESP at cycle 1 with error.
- VALID outputs never deassert before handshake. At most one outstanding transaction. BREADY/RREADY are high only in WRESP/RDATA.
- Back-to-back: a new request held at the RESP cycle is accepted in the following IDLE cycle, so there is one bubble.

## Test plan
- Aligned write, DATA_W=32, addr 0x1000, wdata 0xDEADBEEF, b_en 4'b0011, slave always ready, BRESP=OKAY -> AW/W handshake cycle 1 with WSTRB=0011, stall low cycle 3, mem_error=0.
- Read with ARREADY delayed 4 cycles and RDATA=0xCAFEF00D -> ARVALID held stable 5 cycles; mem_rdata=0xCAFEF00D in the RESP cycle.
- WREADY before AWREADY (2-cycle skew) -> WVALID drops after its handshake; AWVALID holds; exactly one beat each.
- BRESP=SLVERR, then RID mismatch, then RLAST=0 -> mem_error=1 on each; err_count=3.
- Misaligned read at 0x1002 -> no ARVALID; error at cycle 1. DATA_W=64 addr 0x1004 -> error.
- ARESET asserted in RDATA -> all outputs at reset values next cycle; a fresh read completes normally.
